// File: rtl/display_pkg.sv
// Shared types and constants for the display scene scheduler and its pixel helpers.
package display_pkg;

   typedef enum logic [1:0] {
      SCENE_START = 2'd0,
      SCENE_GAME  = 2'd1,
      SCENE_END   = 2'd2
   } scene_e;

   typedef enum logic [1:0] {
      SHOW     = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2
   } sched_state_e;

   // Unity gain is a power of two, so scaling is a multiply followed by a shift.
   localparam int unsigned BRIGHT_FULL  = 8;
   localparam int unsigned BRIGHT_SHIFT = 3;

   // Scene code 3 has no ROM behind it.
   function automatic logic scene_legal(input logic [1:0] s);
      return s != 2'd3;
   endfunction

endpackage

// File: rtl/rgb_scaler.sv
// Combinational brightness scaler: each 8-bit channel becomes (c * bright) >> BRIGHT_SHIFT.
module rgb_scaler
   import display_pkg::*;
(
   input  logic [23:0] i_rgb,
   input  logic [3:0]  i_bright,
   output logic [23:0] o_rgb
);

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      logic [11:0] prod;

      // 12-bit product; bright never exceeds unity, so the shifted result fits 8 bits.
      assign prod = 12'(i_rgb[ch*8 +: 8]) * 12'(i_bright);
      assign o_rgb[ch*8 +: 8] = 8'(prod >> BRIGHT_SHIFT);
   end

endmodule

// File: rtl/display_scene_scheduler.sv
// Scene selector for the VGA path: picks a frame ROM and fades between scenes on frame starts.
module display_scene_scheduler
   import display_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_frame_start,
   input  logic        i_valid,
   input  logic        i_req,
   input  logic [1:0]  i_req_scene,
   input  logic [23:0] i_rgb_start,
   input  logic [23:0] i_rgb_game,
   input  logic [23:0] i_rgb_end,
   output logic [1:0]  o_scene,
   output logic        o_busy,
   output logic [3:0]  o_bright,
   output logic [23:0] o_rgb,
   output logic        o_valid
);

   localparam logic [3:0] StepLast   = 4'(FRAMES_PER_STEP - 1);
   localparam logic [3:0] BrightFull = 4'(BRIGHT_FULL);

   sched_state_e state_q, state_d;
   scene_e       scene_q, scene_d;
   scene_e       pend_q, pend_d;
   logic [3:0]   bright_q, bright_d;
   logic [3:0]   step_cnt_q, step_cnt_d;
   logic [23:0]  rgb_q, rgb_d;
   logic         valid_q;

   logic [23:0]  rgb_sel;
   logic [23:0]  rgb_scaled;
   logic         step_evt;
   logic         req_ok;

   assign step_evt = i_frame_start && (step_cnt_q == StepLast);
   assign req_ok   = i_req && scene_legal(i_req_scene) && (i_req_scene != scene_q);

   // Scheduler next state: accept requests in SHOW, step brightness on frame starts in a fade.
   always_comb begin
      state_d    = state_q;
      scene_d    = scene_q;
      pend_d     = pend_q;
      bright_d   = bright_q;
      step_cnt_d = step_cnt_q;

      case (state_q)
         SHOW: begin
            if (req_ok) begin
               pend_d     = scene_e'(i_req_scene);
               step_cnt_d = '0;
               state_d    = FADE_OUT;
            end
         end

         FADE_OUT: begin
            if (step_evt) begin
               step_cnt_d = '0;
               bright_d   = bright_q - 4'd1;
               // Swap scenes while the screen is black.
               if (bright_q == 4'd1) begin
                  scene_d = pend_q;
                  state_d = FADE_IN;
               end
            end else if (i_frame_start) begin
               step_cnt_d = step_cnt_q + 4'd1;
            end
         end

         FADE_IN: begin
            if (step_evt) begin
               step_cnt_d = '0;
               bright_d   = bright_q + 4'd1;
               if (bright_q == BrightFull - 4'd1) begin
                  state_d = SHOW;
               end
            end else if (i_frame_start) begin
               step_cnt_d = step_cnt_q + 4'd1;
            end
         end

         default: begin
            state_d = SHOW;
         end
      endcase
   end

   // Select the ROM pixel for the displayed scene; anything else shows black.
   always_comb begin
      rgb_sel = '0;
      case (scene_q)
         SCENE_START: rgb_sel = i_rgb_start;
         SCENE_GAME:  rgb_sel = i_rgb_game;
         SCENE_END:   rgb_sel = i_rgb_end;
         default:     rgb_sel = '0;
      endcase
   end

   rgb_scaler u_scaler (
      .i_rgb    (rgb_sel),
      .i_bright (bright_q),
      .o_rgb    (rgb_scaled)
   );

   // Blank the DAC outside the active region.
   always_comb begin
      rgb_d = i_valid ? rgb_scaled : '0;
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= SHOW;
         scene_q    <= SCENE_START;
         pend_q     <= SCENE_START;
         bright_q   <= BrightFull;
         step_cnt_q <= '0;
         rgb_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         scene_q    <= scene_d;
         pend_q     <= pend_d;
         bright_q   <= bright_d;
         step_cnt_q <= step_cnt_d;
         rgb_q      <= rgb_d;
         valid_q    <= i_valid;
      end
   end

   assign o_scene  = scene_q;
   assign o_busy   = (state_q != SHOW);
   assign o_bright = bright_q;
   assign o_rgb    = rgb_q;
   assign o_valid  = valid_q;

endmodule

// File: tb/tb_display_scene_scheduler.sv
// Directed bench for display_scene_scheduler: pixel vector table plus fade/reset sequences.
module tb_display_scene_scheduler;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic        valid;
   logic        req;
   logic [1:0]  req_scene;
   logic [23:0] rgb_start;
   logic [23:0] rgb_game;
   logic [23:0] rgb_end;
   logic [1:0]  scene;
   logic        busy;
   logic [3:0]  bright;
   logic [23:0] rgb;
   logic        vld_o;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic        valid;
      logic [23:0] rgb_start;
      logic [23:0] rgb_game;
      logic [23:0] rgb_end;
      logic [23:0] exp_rgb;
      logic        exp_valid;
   } vec_t;

   vec_t vecs [6];

   display_scene_scheduler #(
      .FRAMES_PER_STEP (2)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_frame_start (frame_start),
      .i_valid       (valid),
      .i_req         (req),
      .i_req_scene   (req_scene),
      .i_rgb_start   (rgb_start),
      .i_rgb_game    (rgb_game),
      .i_rgb_end     (rgb_end),
      .o_scene       (scene),
      .o_busy        (busy),
      .o_bright      (bright),
      .o_rgb         (rgb),
      .o_valid       (vld_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame_start pulse followed by an idle cycle.
   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   initial begin
      n_cmp       = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      valid       = 1'b1;
      req         = 1'b0;
      req_scene   = 2'd0;
      rgb_start   = 24'hFF8040;
      rgb_game    = 24'h00FF00;
      rgb_end     = 24'h0000FF;

      vecs[0] = '{1'b1, 24'h123456, 24'hAAAAAA, 24'hBBBBBB, 24'h123456, 1'b1};
      vecs[1] = '{1'b0, 24'hFFFFFF, 24'hAAAAAA, 24'hBBBBBB, 24'h000000, 1'b0};
      vecs[2] = '{1'b1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 1'b1};
      vecs[3] = '{1'b1, 24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF, 1'b1};
      vecs[4] = '{1'b0, 24'h808080, 24'h111111, 24'h222222, 24'h000000, 1'b0};
      vecs[5] = '{1'b1, 24'h01FE7F, 24'h111111, 24'h222222, 24'h01FE7F, 1'b1};

      // Reset state
      #12;
      check("rst_bright", 32'(bright), 32'd8);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rgb", 32'(rgb), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_rgb", 32'(rgb), 32'hFF8040);
      check("post_rst_valid", 32'(vld_o), 32'd1);
      check("post_rst_scene", 32'(scene), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      // Pixel path at full brightness on the start scene
      for (int i = 0; i < 6; i++) begin
         valid     = vecs[i].valid;
         rgb_start = vecs[i].rgb_start;
         rgb_game  = vecs[i].rgb_game;
         rgb_end   = vecs[i].rgb_end;
         tick();
         check($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].exp_rgb));
         check($sformatf("vec%0d_valid", i), 32'(vld_o), 32'(vecs[i].exp_valid));
      end

      // Dropped requests: current scene and illegal scene
      req = 1'b1; req_scene = 2'd0;
      tick();
      req = 1'b0;
      tick();
      check("drop_same_busy", 32'(busy), 32'd0);
      req = 1'b1; req_scene = 2'd3;
      tick();
      req = 1'b0;
      tick();
      check("drop_ill_busy", 32'(busy), 32'd0);
      check("drop_ill_scene", 32'(scene), 32'd0);

      // Request to game coincident with a frame_start: that pulse is not counted
      req = 1'b1; req_scene = 2'd1; frame_start = 1'b1;
      tick();
      req = 1'b0; frame_start = 1'b0;
      check("acc_busy", 32'(busy), 32'd1);
      check("acc_bright", 32'(bright), 32'd8);
      tick();
      frame();
      check("f1_bright", 32'(bright), 32'd8);
      frame();
      check("f2_bright", 32'(bright), 32'd7);

      for (int k = 3; k <= 32; k++) begin
         if (k == 5) begin
            req = 1'b1; req_scene = 2'd2;
            tick();
            req = 1'b0;
            check("midfade_busy", 32'(busy), 32'd1);
         end
         frame();
         if (k == 8) begin
            check("f8_bright", 32'(bright), 32'd4);
            valid = 1'b1; rgb_start = 24'hFF8041;
            tick();
            check("scale_half_start", 32'(rgb), 32'h7F4020);
         end
         if (k == 15) begin
            check("f15_scene", 32'(scene), 32'd0);
            check("f15_bright", 32'(bright), 32'd1);
         end
         if (k == 16) begin
            check("f16_bright", 32'(bright), 32'd0);
            check("f16_scene", 32'(scene), 32'd1);
            check("f16_busy", 32'(busy), 32'd1);
            valid = 1'b1; rgb_game = 24'hFFFFFF;
            tick();
            check("scale_zero", 32'(rgb), 32'h000000);
         end
         if (k == 24) begin
            check("f24_bright", 32'(bright), 32'd4);
            valid = 1'b1; rgb_game = 24'hFF8041;
            tick();
            check("scale_half_game", 32'(rgb), 32'h7F4020);
         end
         if (k == 31) begin
            check("f31_bright", 32'(bright), 32'd7);
            check("f31_busy", 32'(busy), 32'd1);
         end
      end
      check("f32_bright", 32'(bright), 32'd8);
      check("f32_busy", 32'(busy), 32'd0);
      check("f32_scene", 32'(scene), 32'd1);
      rgb_game = 24'hC0FFEE;
      tick();
      check("game_full_rgb", 32'(rgb), 32'hC0FFEE);

      // Transition to end scene, then async reset part-way through the fade-in
      req = 1'b1; req_scene = 2'd2;
      tick();
      req = 1'b0;
      for (int k = 1; k <= 18; k++) frame();
      check("end_scene", 32'(scene), 32'd2);
      check("end_bright", 32'(bright), 32'd1);
      valid = 1'b1; rgb_end = 24'hFFFFFF;
      tick();
      check("end_rgb_dim", 32'(rgb), 32'h1F1F1F);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_bright", 32'(bright), 32'd8);
      check("arst_scene", 32'(scene), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rgb", 32'(rgb), 32'h0);
      check("arst_valid", 32'(vld_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      frame();
      frame();
      check("post_arst_bright", 32'(bright), 32'd8);
      check("post_arst_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
